// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_EXT = 1'b1
  } owner_e;

  // Ext wins contention unless the CPU has been starved for a full burst.
  function automatic owner_e arb_pick(input logic cpu_req,
                                      input logic ext_req,
                                      input logic cpu_priority);
    owner_e win;
    if (ext_req && !cpu_req) begin
      win = OWNER_EXT;
    end else if (ext_req && cpu_req && !cpu_priority) begin
      win = OWNER_EXT;
    end else begin
      win = OWNER_CPU;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Counts consecutive ext grants made while the CPU is waiting, so the
// arbiter can hand the CPU one slot after MAX_EXT_BURST of them.
module mem_arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_EXT_BURST = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_valid,
  input  logic grant_ext,
  input  logic cpu_req,
  output logic cpu_priority
);

  localparam int unsigned SW = $clog2(MAX_EXT_BURST + 1);
  localparam logic [SW-1:0] MAX_V = SW'(MAX_EXT_BURST);

  logic [SW-1:0] streak_d, streak_q;
  logic          cpu_priority_d, cpu_priority_q;

  // Next streak: bump on a contended ext grant (saturating), clear on any other grant.
  always_comb begin
    streak_d = streak_q;
    if (grant_valid) begin
      if (grant_ext && cpu_req) begin
        if (streak_q != MAX_V) begin
          streak_d = streak_q + SW'(1);
        end else begin
          streak_d = streak_q;
        end
      end else begin
        streak_d = {SW{1'b0}};
      end
    end else begin
      streak_d = streak_q;
    end
    cpu_priority_d = (streak_d == MAX_V);
  end

  // Streak register and its registered saturation flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak_q       <= {SW{1'b0}};
      cpu_priority_q <= 1'b0;
    end else begin
      streak_q       <= streak_d;
      cpu_priority_q <= cpu_priority_d;
    end
  end

  assign cpu_priority = cpu_priority_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the CPU controller and the
// external load/debug port. One strobe per transaction, one-cycle acks.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW            = DEF_AW,
  parameter int unsigned DW            = DEF_DW,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned MAX_EXT_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall,
  output logic          busy
);

  localparam int unsigned   CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

  arb_state_e    state_d, state_q;
  owner_e        owner_d, owner_q;
  logic          we_d, we_q;
  logic [AW-1:0] mem_addr_d, mem_addr_q;
  logic [DW-1:0] mem_wdata_d, mem_wdata_q;
  logic          mem_read_d, mem_read_q;
  logic          mem_write_d, mem_write_q;
  logic          cpu_ack_d, cpu_ack_q;
  logic          ext_ack_d, ext_ack_q;
  logic [DW-1:0] cpu_rdata_d, cpu_rdata_q;
  logic [DW-1:0] ext_rdata_d, ext_rdata_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          busy_d, busy_q;

  owner_e        win_s;
  logic          we_sel_s;
  logic          grant_valid_s;
  logic          grant_ext_s;
  logic          cpu_priority_s;

  mem_arb_streak_ctr #(
    .MAX_EXT_BURST (MAX_EXT_BURST)
  ) u_streak (
    .clock        (clock),
    .reset        (reset),
    .grant_valid  (grant_valid_s),
    .grant_ext    (grant_ext_s),
    .cpu_req      (cpu_req),
    .cpu_priority (cpu_priority_s)
  );

  // Transaction FSM: arbitrate and latch in IDLE, strobe in ISSUE,
  // count out read latency in RDWAIT, pulse the owner's ack in ACK.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    cpu_ack_d     = 1'b0;
    ext_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    ext_rdata_d   = ext_rdata_q;
    cnt_d         = cnt_q;
    win_s         = OWNER_CPU;
    we_sel_s      = 1'b0;
    grant_valid_s = 1'b0;
    grant_ext_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || ext_req) begin
          win_s         = arb_pick(cpu_req, ext_req, cpu_priority_s);
          grant_valid_s = 1'b1;
          grant_ext_s   = (win_s == OWNER_EXT);
          owner_d       = win_s;
          if (win_s == OWNER_EXT) begin
            we_sel_s    = ext_we;
            mem_addr_d  = ext_addr;
            mem_wdata_d = ext_wdata;
          end else begin
            we_sel_s    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
          we_d        = we_sel_s;
          mem_write_d = we_sel_s;
          mem_read_d  = !we_sel_s;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
          if (owner_q == OWNER_EXT) begin
            ext_ack_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
          end
        end else begin
          state_d = RDWAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      RDWAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ACK;
          if (owner_q == OWNER_EXT) begin
            ext_rdata_d = mem_rdata;
            ext_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_CPU;
      we_q        <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
      cpu_rdata_q <= {DW{1'b0}};
      ext_rdata_q <= {DW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign busy      = busy_q;
  // Stall reacts to ext_req immediately so the CPU FSM holds off in the same cycle.
  assign cpu_stall = ext_req | ((owner_q == OWNER_EXT) && (state_q != IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected strobes/acks/stall values,
// a negedge monitor pops and compares them as the DUTs present outputs.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut0: RD_LAT=1
  logic        reset, cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_ack, ext_ack, mem_read, mem_write, cpu_stall, busy;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  // dut3: RD_LAT=3
  logic        reset3, cpu_req3, cpu_we3, ext_req3, ext_we3;
  logic [15:0] cpu_addr3, cpu_wdata3, ext_addr3, ext_wdata3;
  logic        cpu_ack3, ext_ack3, mem_read3, mem_write3, cpu_stall3, busy3;
  logic [15:0] cpu_rdata3, ext_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_EXT_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .busy(busy)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .MAX_EXT_BURST(4)) dut3 (
    .clock(clock), .reset(reset3),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
    .ext_req(ext_req3), .ext_we(ext_we3), .ext_addr(ext_addr3), .ext_wdata(ext_wdata3),
    .ext_ack(ext_ack3), .ext_rdata(ext_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_read(mem_read3), .mem_write(mem_write3),
    .mem_rdata(mem_rdata3), .cpu_stall(cpu_stall3), .busy(busy3)
  );

  // Memory models: data appears RD_LAT cycles after the read strobe.
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] rp0 = 16'h0000;
  logic [15:0] rp3 [0:2];
  always @(posedge clock) begin
    if (mem_write) mem0[mem_addr] <= mem_wdata;
    if (mem_read) rp0 <= mem0[mem_addr];
    if (mem_write3) mem3[mem_addr3] <= mem_wdata3;
    rp3[0] <= mem_read3 ? mem3[mem_addr3] : 16'h0000;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mem_rdata  = rp0;
  assign mem_rdata3 = rp3[2];

  typedef struct { int d; int c; logic we; logic [15:0] addr; logic [15:0] wdata; } strb_t;
  typedef struct { int d; int port; int c; logic [15:0] crd; logic [15:0] erd; } ack_t;
  typedef struct { int c; logic v; } stall_t;
  strb_t  strb_q[$];
  ack_t   ack_q[$];
  stall_t stall_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void exp_strb(input int d, input int c, input logic we,
                                   input logic [15:0] a, input logic [15:0] w);
    strb_t s;
    s.d = d; s.c = c; s.we = we; s.addr = a; s.wdata = w;
    strb_q.push_back(s);
  endfunction

  function automatic void exp_ack(input int d, input int port, input int c,
                                  input logic [15:0] crd, input logic [15:0] erd);
    ack_t s;
    s.d = d; s.port = port; s.c = c; s.crd = crd; s.erd = erd;
    ack_q.push_back(s);
  endfunction

  function automatic void exp_stall(input int c, input logic v);
    stall_t s;
    s.c = c; s.v = v;
    stall_q.push_back(s);
  endfunction

  task automatic mon_strobe(input int d, input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] w);
    strb_t s;
    if (rd || wr) begin
      chk($sformatf("strobe_excl_d%0d", d), {31'd0, rd & wr}, 32'd0);
      checks++;
      if (strb_q.size() == 0 || strb_q[0].d != d) begin
        errors++;
        $display("FAIL unexpected_strobe d=%0d cyc=%0d actual rd=%0b wr=%0b required none", d, cyc, rd, wr);
      end else begin
        s = strb_q.pop_front();
        if (s.c != cyc || s.we != wr || s.addr != a || (s.we && s.wdata != w)) begin
          errors++;
          $display("FAIL strobe d=%0d actual cyc=%0d we=%0b addr=%h wdata=%h required cyc=%0d we=%0b addr=%h wdata=%h",
                   d, cyc, wr, a, w, s.c, s.we, s.addr, s.wdata);
        end
      end
    end
  endtask

  task automatic mon_ack(input int d, input logic ca, input logic ea,
                         input logic [15:0] crd, input logic [15:0] erd);
    ack_t s;
    int   port;
    if (ca || ea) begin
      chk($sformatf("ack_excl_d%0d", d), {31'd0, ca & ea}, 32'd0);
      port = ea ? 1 : 0;
      checks++;
      if (ack_q.size() == 0 || ack_q[0].d != d) begin
        errors++;
        $display("FAIL unexpected_ack d=%0d cyc=%0d actual port=%0d required none", d, cyc, port);
      end else begin
        s = ack_q.pop_front();
        if (s.c != cyc || s.port != port || s.crd != crd || s.erd != erd) begin
          errors++;
          $display("FAIL ack d=%0d actual cyc=%0d port=%0d cpu_rdata=%h ext_rdata=%h required cyc=%0d port=%0d cpu_rdata=%h ext_rdata=%h",
                   d, cyc, port, crd, erd, s.c, s.port, s.crd, s.erd);
        end
      end
    end
  endtask

  // Monitor: compare whatever the DUTs present this cycle, flag anything overdue.
  always @(negedge clock) begin
    stall_t st;
    mon_strobe(0, mem_read, mem_write, mem_addr, mem_wdata);
    mon_strobe(1, mem_read3, mem_write3, mem_addr3, mem_wdata3);
    mon_ack(0, cpu_ack, ext_ack, cpu_rdata, ext_rdata);
    mon_ack(1, cpu_ack3, ext_ack3, cpu_rdata3, ext_rdata3);
    if (strb_q.size() > 0 && strb_q[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL missing_strobe cyc=%0d actual none required cyc=%0d addr=%h", cyc, strb_q[0].c, strb_q[0].addr);
      void'(strb_q.pop_front());
    end
    if (ack_q.size() > 0 && ack_q[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL missing_ack cyc=%0d actual none required cyc=%0d port=%0d", cyc, ack_q[0].c, ack_q[0].port);
      void'(ack_q.pop_front());
    end
    while (stall_q.size() > 0 && stall_q[0].c <= cyc) begin
      st = stall_q.pop_front();
      chk($sformatf("cpu_stall@%0d", st.c), {31'd0, cpu_stall}, {31'd0, st.v});
    end
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] w);
    case (p)
      0: begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = w; end
      1: begin ext_req = req; ext_we = we; ext_addr = a; ext_wdata = w; end
      2: begin cpu_req3 = req; cpu_we3 = we; cpu_addr3 = a; cpu_wdata3 = w; end
      default: begin ext_req3 = req; ext_we3 = we; ext_addr3 = a; ext_wdata3 = w; end
    endcase
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0: return cpu_ack;
      1: return ext_ack;
      2: return cpu_ack3;
      default: return ext_ack3;
    endcase
  endfunction

  // Requester: hold req through n acks (each extra cycle high is a new transaction), then drop.
  task automatic run_port(input int p, input logic we, input logic [15:0] a,
                          input logic [15:0] w, input int n);
    bit got;
    drive(p, 1'b1, we, a, w);
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clock);
        got = ack_of(p);
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL ack_timeout port=%0d actual none required ack within 60 cycles", p);
      end
    end
    @(posedge clock); #1;
    drive(p, 1'b0, we, a, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    reset = 1'b0; reset3 = 1'b0;
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Test 1: outputs stay clear while in reset regardless of requests.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      cpu_req = i[0]; ext_req = i[1]; cpu_we = i[1];
      cpu_addr = 16'hA5A0 + 16'(i); ext_addr = 16'h5A50 + 16'(i);
      cpu_wdata = 16'h1111; ext_wdata = 16'h2222;
      @(negedge clock);
      chk("reset_ctl", {27'd0, mem_read, mem_write, cpu_ack, ext_ack, busy}, 32'd0);
      chk("reset_mem_regs", {mem_addr, mem_wdata}, 32'd0);
      chk("reset_rdata", {cpu_rdata, ext_rdata}, 32'd0);
      chk("reset_stall", {31'd0, cpu_stall}, {31'd0, ext_req});
    end
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    end

    // Test 2: ext write 0x0001 <- 0x9040.
    @(posedge clock); #1;
    t = cyc;
    exp_strb(0, t + 1, 1'b1, 16'h0001, 16'h9040);
    exp_ack(0, 1, t + 2, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) exp_stall(t + k, 1'b1);
    exp_stall(t + 3, 1'b0);
    run_port(1, 1'b1, 16'h0001, 16'h9040, 1);

    // Test 3: cpu read 0x0001 -> 0x9040, ext_rdata untouched.
    @(posedge clock); #1;
    t = cyc;
    exp_strb(0, t + 1, 1'b0, 16'h0001, 16'h0000);
    exp_ack(0, 0, t + 3, 16'h9040, 16'h0000);
    run_port(0, 1'b0, 16'h0001, 16'h0000, 1);

    // Test 4: both hold write requests; E,E,E,E,C,E,E,E,E,C,E every 3 cycles.
    @(posedge clock); #1;
    t = cyc;
    for (int k = 0; k < 11; k++) begin
      if (k == 4 || k == 9) begin
        exp_strb(0, t + 1 + 3 * k, 1'b1, 16'h0C00, 16'h0CC3);
        exp_ack(0, 0, t + 2 + 3 * k, 16'h9040, 16'h0000);
      end else begin
        exp_strb(0, t + 1 + 3 * k, 1'b1, 16'h0E00, 16'h5EE5);
        exp_ack(0, 1, t + 2 + 3 * k, 16'h9040, 16'h0000);
      end
    end
    fork
      run_port(0, 1'b1, 16'h0C00, 16'h0CC3, 2);
      run_port(1, 1'b1, 16'h0E00, 16'h5EE5, 9);
    join

    // Test 6: ext read arrives while a CPU write is in ISSUE.
    @(posedge clock); #1;
    t = cyc;
    exp_strb(0, t + 1, 1'b1, 16'h0002, 16'h1234);
    exp_ack(0, 0, t + 2, 16'h9040, 16'h0000);
    exp_strb(0, t + 4, 1'b0, 16'h0E00, 16'h0000);
    exp_ack(0, 1, t + 6, 16'h9040, 16'h5EE5);
    exp_stall(t, 1'b0);
    for (int k = 1; k < 7; k++) exp_stall(t + k, 1'b1);
    exp_stall(t + 7, 1'b0);
    fork
      run_port(0, 1'b1, 16'h0002, 16'h1234, 1);
      begin
        @(posedge clock); #1;
        run_port(1, 1'b0, 16'h0E00, 16'h0000, 1);
      end
    join

    // Test 5 (RD_LAT=3): reset during RDWAIT drops the read, reissue completes.
    @(posedge clock); #1;
    reset3 = 1'b1;
    @(posedge clock); #1;
    t = cyc;
    exp_strb(1, t + 1, 1'b1, 16'h0007, 16'hA5A5);
    exp_ack(1, 1, t + 2, 16'h0000, 16'h0000);
    run_port(3, 1'b1, 16'h0007, 16'hA5A5, 1);
    t = cyc;
    exp_strb(1, t + 1, 1'b0, 16'h0007, 16'h0000);
    drive(2, 1'b1, 1'b0, 16'h0007, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    reset3 = 1'b0;
    @(negedge clock);
    chk("rdwait_reset_ctl", {26'd0, mem_read3, mem_write3, cpu_ack3, ext_ack3, busy3, cpu_stall3}, 32'd0);
    chk("rdwait_reset_rdata", {cpu_rdata3, ext_rdata3}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset3 = 1'b1;
    t2 = cyc;
    exp_strb(1, t2 + 1, 1'b0, 16'h0007, 16'h0000);
    exp_ack(1, 0, t2 + 5, 16'hA5A5, 16'h0000);
    run_port(2, 1'b0, 16'h0007, 16'h0000, 1);

    repeat (5) @(negedge clock);
    chk("strb_q_drained", strb_q.size(), 32'd0);
    chk("ack_q_drained", ack_q.size(), 32'd0);
    chk("stall_q_drained", stall_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 16-bit unified memory of the multicycle CPU between two requesters: the CPU datapath controller and the external load/debug port (Mem_Addr/Write_Data/MemRead1/MemWrite1 path).
- Each requester holds a request until it receives a one-cycle ack.
- Issues exactly one memory strobe per transaction.
- Asserts cpu_stall while the external port owns or is claiming memory.
- Sits between CPU_top_module's control FSM and the memory instance.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, memory read latency in cycles (>=1); rdata valid RD_LAT cycles after the mem_read strobe
MAX_EXT_BURST, 4, max consecutive ext grants while cpu_req is pending (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU transaction request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  CPU read data, valid from cpu_ack until next CPU read completes
ext_req/ext_we/ext_addr/ext_wdata  in  1/1/AW/DW  external port, same semantics as cpu_*
ext_ack  out  1  one-cycle completion pulse
ext_rdata  out  DW  external read data
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_read  out  1  read strobe, one cycle per read
mem_write  out  1  write strobe, one cycle per write
mem_rdata  in  DW  memory read data
cpu_stall  out  1  = ext_req OR (owner==EXT AND state!=IDLE)
busy  out  1  state!=IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, owner CPU, all strobes/acks 0, mem_addr/mem_wdata/cpu_rdata/ext_rdata = 0, streak = 0. Any in-flight transaction is dropped with no ack; the requester reissues.
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- IDLE: if any req is high, arbitrate, latch owner/we/addr/wdata into the mem_* registers, then go to ISSUE. Otherwise stay.
- ISSUE: drive mem_write=we or mem_read=!we for exactly this cycle. Write goes to ACK; read goes to RDWAIT.
- RDWAIT: lasts RD_LAT cycles (down-counter). On the last cycle, capture mem_rdata into the owner's rdata register. Go to ACK.
- ACK: pulse the owner's ack for one cycle, then return to IDLE.
- Latency from req sampled in IDLE at cycle t:
  - write: strobe at t+1, ack at t+2, back in IDLE at t+3.
  - read: strobe at t+1, ack at t+2+RD_LAT.
- Requester contract: req stays high and addr/we/wdata stay stable until ack. If req is still high in the IDLE cycle after ack, that is a new transaction. Requests seen outside IDLE only wait.
- Arbitration (IDLE only):
  - Only one req high: that requester wins.
  - Both high: ext wins unless streak==MAX_EXT_BURST, in which case cpu wins.
  - streak increments on each ext grant made while cpu_req is high. It clears on any cpu grant, or on an ext grant made while cpu_req is low. It saturates at MAX_EXT_BURST.
- mem_read and mem_write are never both 1. No strobe occurs in IDLE, RDWAIT or ACK.
- mem_addr/mem_wdata hold their last value when idle.
- The non-owner's rdata is unchanged by the other requester's reads.
- cpu_stall is combinational from ext_req and registered state. A CPU transaction already past IDLE completes even if ext_req rises.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RDWAIT, ACK}
  - owner encoding OWNER_CPU=0, OWNER_EXT=1
  - default AW/DW constants
- Sub-module mem_arb_streak_ctr: streak register, saturation and clear logic. Outputs cpu_priority = (streak==MAX_EXT_BURST).
- FSM, latches and rdata capture stay in the top.

Test Plan:
1. Hold reset=0 while toggling reqs → all outputs 0, busy=0. Release with no reqs → no strobes for 10 cycles.
2. ext write, addr 0x0001, data 0x9040, req at t → mem_write=1, mem_addr=0x0001, mem_wdata=0x9040 at t+1; ext_ack at t+2; cpu_stall high t..t+2.
3. cpu read, addr 0x0001, RD_LAT=1, memory returns 0x9040 → mem_read at t+1, cpu_ack at t+3, cpu_rdata=0x9040; ext_rdata unchanged.
4. cpu_req and ext_req held continuously, both writes, MAX_EXT_BURST=4 → grant sequence E,E,E,E,C,E,E,E,E,C; one transaction per 3 cycles; never both strobes.
5. Reset asserted during RDWAIT (RD_LAT=3) → strobes/acks drop immediately and no ack occurs. After release the reissued read completes with ack at t+5.
6. ext_req rises while a CPU write is in ISSUE → CPU write completes, cpu_ack at t+2. Ext granted in the next IDLE; cpu_stall high from ext_req rise until ext_ack.
